// File: rtl/fighter_pkg.sv
// Shared fighter definitions. The renderer uses the same action codes to pick
// its sprite sheet.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    KICK    = 3'd2,
    PUNCH   = 3'd3,
    JUMP    = 3'd4,
    DODGE   = 3'd5,
    RECOVER = 3'd6
  } action_e;

endpackage

// File: rtl/fighter_frame_counter.sv
// Per-action frame counter. It clears on request and otherwise counts frame
// ticks, wrapping to zero after reaching last_i.
module fighter_frame_counter #(
  parameter int FRAME_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               tick_i,
  input  logic               clear_i,
  input  logic [FRAME_W-1:0] last_i,
  output logic [FRAME_W-1:0] count_o,
  output logic               terminal_o
);

  logic [FRAME_W-1:0] count_q, count_d;

  assign terminal_o = (count_q == last_i);
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (tick_i) begin
      if (clear_i || terminal_o) count_d = '0;
      else                       count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/fighter_action_fsm.sv
// Fighter action sequencer. It advances only on frame ticks, and a one-deep
// buffer holds attack presses so that attacks can be chained.
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter int FRAME_W         = 4,
  parameter int KICK_FRAMES     = 6,
  parameter int PUNCH_FRAMES    = 4,
  parameter int JUMP_FRAMES     = 8,
  parameter int DODGE_FRAMES    = 5,
  parameter int WALK_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int ACTIVE_START    = 2,
  parameter int ACTIVE_END      = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               kick_i,
  input  logic               fight_i,
  input  logic               jump_i,
  input  logic               dodge_i,
  output action_e            action_o,
  output logic [FRAME_W-1:0] anim_frame_o,
  output logic               facing_left_o,
  output logic               attack_active_o,
  output logic               busy_o,
  output logic               stand_left_o,
  output logic               stand_right_o
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_WALK    = WALK;
  localparam logic [2:0] S_KICK    = KICK;
  localparam logic [2:0] S_PUNCH   = PUNCH;
  localparam logic [2:0] S_JUMP    = JUMP;
  localparam logic [2:0] S_DODGE   = DODGE;
  localparam logic [2:0] S_RECOVER = RECOVER;

  localparam logic [FRAME_W-1:0] KICK_LAST  = FRAME_W'(KICK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] PUNCH_LAST = FRAME_W'(PUNCH_FRAMES - 1);
  localparam logic [FRAME_W-1:0] JUMP_LAST  = FRAME_W'(JUMP_FRAMES - 1);
  localparam logic [FRAME_W-1:0] DODGE_LAST = FRAME_W'(DODGE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] WALK_LAST  = FRAME_W'(WALK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] COOL_LAST  =
    FRAME_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

  if (KICK_FRAMES < 1 || KICK_FRAMES > (1 << FRAME_W) ||
      PUNCH_FRAMES < 1 || PUNCH_FRAMES > (1 << FRAME_W) ||
      JUMP_FRAMES < 1 || JUMP_FRAMES > (1 << FRAME_W) ||
      DODGE_FRAMES < 1 || DODGE_FRAMES > (1 << FRAME_W) ||
      WALK_FRAMES < 1 || WALK_FRAMES > (1 << FRAME_W) ||
      COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > (1 << FRAME_W) ||
      ACTIVE_START > ACTIVE_END) begin : g_bad_params
    $error("fighter_action_fsm: illegal duration or hit-window parameters");
  end

  logic [2:0]         state_q, state_d;
  logic               facingLeft_q, facingLeft_d;
  logic               bufValid_q, bufValid_d;
  logic               bufKick_q, bufKick_d;
  logic [FRAME_W-1:0] lastCount, count;
  logic               terminal;
  logic               press, effKick;
  logic [2:0]         resolved;
  logic [31:0]        countWide;

  always_comb begin
    lastCount = '0;
    case (state_q)
      S_WALK:    lastCount = WALK_LAST;
      S_KICK:    lastCount = KICK_LAST;
      S_PUNCH:   lastCount = PUNCH_LAST;
      S_JUMP:    lastCount = JUMP_LAST;
      S_DODGE:   lastCount = DODGE_LAST;
      S_RECOVER: lastCount = COOL_LAST;
      default:   lastCount = '0;
    endcase
  end

  fighter_frame_counter #(.FRAME_W(FRAME_W)) u_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .tick_i     (frame_tick_i),
    .clear_i    (state_d != state_q),
    .last_i     (lastCount),
    .count_o    (count),
    .terminal_o (terminal)
  );

  // A press on the exiting tick counts as buffered, so a late press still chains
  always_comb begin
    press    = kick_i | fight_i;
    effKick  = press ? kick_i : bufKick_q;
    resolved = (bufValid_q | press) ? (effKick ? S_KICK : S_PUNCH) : S_IDLE;
  end

  always_comb begin
    state_d      = state_q;
    facingLeft_d = facingLeft_q;
    bufValid_d   = bufValid_q;
    bufKick_d    = bufKick_q;
    if (frame_tick_i) begin
      case (state_q)
        S_IDLE, S_WALK: begin
          if (left_i && !right_i)      facingLeft_d = 1'b1;
          else if (right_i && !left_i) facingLeft_d = 1'b0;
          if (dodge_i) begin
            state_d    = S_DODGE;
            bufValid_d = 1'b0;
          end else if (jump_i) begin
            state_d    = S_JUMP;
            bufValid_d = 1'b0;
          end else if (kick_i)           state_d = S_KICK;
          else if (fight_i)              state_d = S_PUNCH;
          else if (left_i ^ right_i)     state_d = S_WALK;
          else                           state_d = S_IDLE;
        end
        S_KICK, S_PUNCH, S_RECOVER: begin
          if (press) begin
            bufValid_d = 1'b1;
            bufKick_d  = kick_i;
          end
          if (terminal) begin
            if (state_q != S_RECOVER && COOLDOWN_FRAMES > 0) begin
              state_d = S_RECOVER;
            end else begin
              state_d    = resolved;
              bufValid_d = 1'b0;
            end
          end
        end
        S_JUMP, S_DODGE: begin
          if (terminal) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      facingLeft_q <= 1'b0;
      bufValid_q   <= 1'b0;
      bufKick_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      facingLeft_q <= facingLeft_d;
      bufValid_q   <= bufValid_d;
      bufKick_q    <= bufKick_d;
    end
  end

  assign countWide       = 32'(count);
  assign action_o        = action_e'(state_q);
  assign anim_frame_o    = (state_q == S_IDLE) ? '0 : count;
  assign facing_left_o   = facingLeft_q;
  assign attack_active_o = (state_q == S_KICK || state_q == S_PUNCH) &&
                           (countWide >= 32'(ACTIVE_START)) &&
                           (countWide <= 32'(ACTIVE_END));
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_WALK);
  assign stand_left_o    = (state_q == S_IDLE) && facingLeft_q;
  assign stand_right_o   = (state_q == S_IDLE) && !facingLeft_q;

endmodule

// File: doc/fighter_action_fsm.md
FIGHTER_ACTION_FSM -- requirements
Module: fighter_action_fsm

Interface
REQ-001 SHALL have parameter FRAME_W, default 4: width of frame counter and anim_frame.
REQ-002 SHALL have parameters KICK_FRAMES=6, PUNCH_FRAMES=4, JUMP_FRAMES=8, DODGE_FRAMES=5: action durations, in frame ticks.
REQ-003 SHALL have parameters WALK_FRAMES=4 (walk cycle length), COOLDOWN_FRAMES=2 (post-attack recovery; 0 allowed), ACTIVE_START=2, ACTIVE_END=3 (attack hit window, counter values inclusive).
REQ-004 Clk  input  1  single clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame; the only advance enable.
REQ-007 left, right, kick, fight, jump, dodge  input  1 each  level-sampled player controls.
REQ-008 action  output  3  current action code (fighter_pkg::action_e).
REQ-009 anim_frame  output  FRAME_W  animation frame index within current action.
REQ-010 facing_left  output  1  1 = facing left, 0 = facing right.
REQ-011 attack_active  output  1  hit window asserted.
REQ-012 busy  output  1  high in any state other than IDLE and WALK.
REQ-013 stand_left, stand_right  output  1 each  legacy: stand_left = IDLE & facing_left; stand_right = IDLE & ~facing_left.

Function
REQ-014 States SHALL be IDLE, WALK, KICK, PUNCH, JUMP, DODGE, RECOVER; all outputs are Moore, decoded from registered state, counter, facing.
REQ-015 State, counter, facing and buffer SHALL change only on cycles with frame_tick=1; otherwise hold.
REQ-016 From IDLE/WALK, next state priority: dodge > jump > kick > fight > (left XOR right -> WALK) > IDLE; counter loads 0 on every state change.
REQ-017 In IDLE/WALK, facing SHALL update at each tick: left&~right -> 1, right&~left -> 0, else hold; facing frozen in all other states.
REQ-018 WALK counter SHALL increment per tick and wrap from WALK_FRAMES-1 to 0; anim_frame = counter; IDLE anim_frame = 0.
REQ-019 In KICK/PUNCH/JUMP/DODGE the counter SHALL increment per tick; at the tick where counter == duration-1: KICK/PUNCH -> RECOVER (or directly to resolved next state of REQ-021 if COOLDOWN_FRAMES=0); JUMP/DODGE -> IDLE.
REQ-020 RECOVER SHALL last COOLDOWN_FRAMES ticks (counter 0..COOLDOWN_FRAMES-1), anim_frame = counter.
REQ-021 A kick or fight input sampled on a tick during KICK, PUNCH or RECOVER SHALL set a one-deep buffer (kick wins if both; later press overwrites earlier); on exit to IDLE the buffered attack SHALL be taken instead of IDLE and the buffer cleared.
REQ-022 jump, dodge, left, right SHALL be ignored while busy; buffer SHALL be cleared on entry to JUMP/DODGE.
REQ-023 attack_active SHALL be 1 only in KICK or PUNCH with ACTIVE_START <= counter <= ACTIVE_END.
REQ-024 Counter SHALL never exceed max(durations)-1; no overflow permitted for any legal parameter set.

Reset
REQ-025 Reset SHALL override frame_tick and take effect at the next Clk edge, including mid-action.
REQ-026 Reset values: state IDLE, counter 0, buffer empty, facing_left 0, action IDLE, anim_frame 0, attack_active 0, busy 0, stand_left 0, stand_right 1.

Structure
REQ-027 action_e enum (IDLE=0, WALK=1, KICK=2, PUNCH=3, JUMP=4, DODGE=5, RECOVER=6) SHALL live in package fighter_pkg, shared with the renderer.
REQ-028 Frame counter (load-zero, increment-on-tick, wrap/terminal compare) SHALL be sub-module fighter_frame_counter.
REQ-029 Elaboration check SHALL fail if any duration is 0 or > 2**FRAME_W, or ACTIVE_START > ACTIVE_END.

Verification (defaults)
REQ-030 Reset, idle 3 ticks -> action=0, stand_right=1, stand_left=0, anim_frame=0.
REQ-031 left held 6 ticks -> WALK, facing_left=1, anim_frame 0,1,2,3,0,1; release -> IDLE, stand_left=1.
REQ-032 kick 1 tick -> KICK 6 ticks, attack_active only at anim_frame 2-3, RECOVER 2 ticks, IDLE; busy high for 8 ticks.
REQ-033 fight during RECOVER of kick -> PUNCH entered directly after RECOVER, no IDLE tick; buffer cleared.
REQ-034 dodge+jump+kick same tick -> DODGE 5 ticks, then IDLE; ticks without frame_tick hold all outputs.
REQ-035 Reset asserted at JUMP anim_frame 4 -> next edge all outputs at REQ-026 values.
